// File: rtl/ab_ctrl_pkg.sv
// Shared types for the a/b mode controller: state encoding and reset state.
package ab_ctrl_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } ab_state_t;

  localparam ab_state_t AB_RESET_STATE = S0;

endpackage

// File: rtl/ab_ctrl_fsm.sv
// Three-state Moore mode tracker: S1 on a alone, S2 while a and b stay high together.
module ab_ctrl_fsm
  import ab_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic y0,
  output logic y1
);

  ab_state_t state_reg;
  ab_state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= AB_RESET_STATE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S0;
    case (state_reg)
      S0: begin
        if (a && b) begin
          state_next = S2;
        end else if (a) begin
          state_next = S1;
        end else begin
          state_next = S0;
        end
      end
      S1: begin
        state_next = a ? S0 : S1;
      end
      S2: begin
        state_next = (a && b) ? S2 : S0;
      end
      // The unused 2'b11 encoding recovers to idle.
      default: begin
        state_next = S0;
      end
    endcase
  end

  // Outputs come from the state register only, so they are one-hot or zero.
  always_comb begin
    y0 = (state_reg == S1);
    y1 = (state_reg == S2);
  end

endmodule

// File: tb/tb_ab_ctrl_fsm.sv
// Self-checking bench for ab_ctrl_fsm: directed mode walks plus randomized run against a mode model.
module tb_ab_ctrl_fsm;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic y0;
  logic y1;

  int total;
  int bad;
  int mode;   // 0 idle, 1 single-qualifier mode, 2 dual-qualifier mode

  ab_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .y0  (y0),
    .y1  (y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Mode rules stated directly: idle enters mode 1 on a alone, mode 2 on a with b;
  // mode 1 leaves on any a; mode 2 survives only while a and b both stay high.
  function automatic int model_next(int cur, logic r, logic ia, logic ib);
    if (r) return 0;
    if (cur == 0) return ia ? (ib ? 2 : 1) : 0;
    if (cur == 1) return ia ? 0 : 1;
    return (ia && ib) ? 2 : 0;
  endfunction

  function automatic logic [1:0] model_out(int m);
    logic [1:0] o;
    o = 2'b00;
    if (m == 1) o[0] = 1'b1;
    if (m == 2) o[1] = 1'b1;
    return o;
  endfunction

  // One clock edge with the given inputs, then compare against the model.
  task automatic step(input string tag, input logic r, input logic ia, input logic ib);
    rst = r;
    a   = ia;
    b   = ib;
    @(posedge clk);
    #1;
    mode = model_next(mode, r, ia, ib);
    check(tag, {30'd0, y1, y0}, {30'd0, model_out(mode)});
    check({tag, "_mutex"}, {31'd0, y0 & y1}, 32'd0);
    $display("txn %-12s rst=%0b a=%0b b=%0b -> y1y0=%0b%0b (model mode %0d)", tag, r, ia, ib, y1, y0, mode);
  endtask

  initial begin
    logic r_rnd;
    logic a_rnd;
    logic b_rnd;
    total = 0;
    bad   = 0;
    mode  = 0;
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;

    // Reset and idle hold
    step("reset", 1'b1, 1'b0, 1'b0);
    check("reset_y0", {31'd0, y0}, 32'd0);
    check("reset_y1", {31'd0, y1}, 32'd0);
    step("idle1", 1'b0, 1'b0, 1'b0);
    step("idle2", 1'b0, 1'b0, 1'b0);

    // S0 -> S1 -> S1 -> S0
    step("s0_to_s1", 1'b0, 1'b1, 1'b0);
    check("s1_y0", {31'd0, y0}, 32'd1);
    step("s1_hold", 1'b0, 1'b0, 1'b0);
    check("s1_hold_y0", {31'd0, y0}, 32'd1);
    step("s1_to_s0", 1'b0, 1'b1, 1'b0);
    check("s1_exit", {30'd0, y1, y0}, 32'd0);

    // S0 -> S2, hold three edges, exit on b low to S0 (not S1)
    step("s0_to_s2", 1'b0, 1'b1, 1'b1);
    check("s2_y1", {31'd0, y1}, 32'd1);
    for (int i = 0; i < 3; i++) step("s2_hold", 1'b0, 1'b1, 1'b1);
    check("s2_hold_y1", {30'd0, y1, y0}, 32'd2);
    step("s2_exit", 1'b0, 1'b1, 1'b0);
    check("s2_exit_s0", {30'd0, y1, y0}, 32'd0);

    // S1 ignores b, then a with b returns to S0 rather than S2
    step("s0_to_s1b", 1'b0, 1'b1, 1'b0);
    step("s1_b_ign", 1'b0, 1'b0, 1'b1);
    step("s1_b_ign", 1'b0, 1'b0, 1'b1);
    check("s1_b_y0", {30'd0, y1, y0}, 32'd1);
    step("s1_ab_exit", 1'b0, 1'b1, 1'b1);
    check("s1_ab_s0", {30'd0, y1, y0}, 32'd0);

    // Reset mid-operation from S2, then re-enter S2
    step("to_s2", 1'b0, 1'b1, 1'b1);
    step("rst_in_s2", 1'b1, 1'b1, 1'b1);
    check("rst_mid", {30'd0, y1, y0}, 32'd0);
    step("re_s2", 1'b0, 1'b1, 1'b1);
    check("re_s2_y1", {30'd0, y1, y0}, 32'd2);

    // Randomized run with occasional reset
    for (int i = 0; i < 200; i++) begin
      r_rnd = ($urandom_range(0, 19) == 0);
      a_rnd = 1'($urandom_range(0, 1));
      b_rnd = 1'($urandom_range(0, 1));
      step("random", r_rnd, a_rnd, b_rnd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
